// File: rtl/pps_divider_multi.sv
// Multi-channel PPS divider: one shared PPS synchroniser and microsecond timebase
// driving N_CH independent pulse generators with per-channel divide, phase, width and polarity.
`timescale 1ns/1ps
module pps_divider_multi #(
  parameter int N_CH        = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int PHASE_WIDTH = 24,
  parameter int CLKS_PER_US = 10
) (
  input  logic                        i_clk_10,
  input  logic                        i_rst,
  input  logic                        i_pps_raw,
  input  logic [N_CH-1:0]             i_start,
  input  logic [N_CH-1:0]             i_stop,
  input  logic [N_CH-1:0]             i_periodic,
  input  logic [N_CH-1:0]             i_polarity,
  input  logic [N_CH*DATA_WIDTH-1:0]  i_div_number,
  input  logic [N_CH*PHASE_WIDTH-1:0] i_phase_us,
  input  logic [N_CH*DATA_WIDTH-1:0]  i_width_us,
  input  logic [N_CH-1:0]             i_clr_overrun,
  output logic [N_CH-1:0]             o_pps_divided,
  output logic [N_CH-1:0]             o_active,
  output logic [N_CH-1:0]             o_overrun,
  output logic                        o_pps_edge
);

  localparam int PW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;

  typedef enum logic [2:0] {IDLE, ARMED, PHASE, WIDTH, DONE} state_t;

  logic          sync1, sync2, sync_dly, pps_edge, pps_rise, us_tick;
  logic [PW-1:0] presc;

  assign pps_rise   = sync2 & ~sync_dly;
  assign us_tick    = (presc == '0);
  assign o_pps_edge = pps_edge;

  // Prescaler is realigned on every PPS so the tick lands on cycle E + k*CLKS_PER_US
  always_ff @(posedge i_clk_10 or posedge i_rst) begin
    if (i_rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      sync_dly <= 1'b0;
      pps_edge <= 1'b0;
      presc    <= '0;
    end else begin
      sync1    <= i_pps_raw;
      sync2    <= sync1;
      sync_dly <= sync2;
      pps_edge <= pps_rise;
      if (pps_rise || presc == PW'(CLKS_PER_US - 1))
        presc <= '0;
      else
        presc <= presc + 1'b1;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    state_t                 state, state_nx;
    logic [DATA_WIDTH-1:0]  div_in, width_in, div_max, div_cnt, div_cnt_nx, width_sh, width_sh_nx;
    logic [PHASE_WIDTH-1:0] phase_in, us_cnt, us_cnt_nx, phase_sh, phase_sh_nx;
    logic                   pol_sh, pol_sh_nx, per_sh, per_sh_nx, overrun, overrun_nx;
    logic                   run, fire, busy;

    assign div_in   = i_div_number[k*DATA_WIDTH +: DATA_WIDTH];
    assign width_in = i_width_us[k*DATA_WIDTH +: DATA_WIDTH];
    assign phase_in = i_phase_us[k*PHASE_WIDTH +: PHASE_WIDTH];
    assign div_max  = (div_in == '0) ? '0 : div_in - 1'b1;
    assign run      = i_start[k] & ~i_stop[k];
    assign fire     = pps_edge & (div_cnt == '0);
    assign busy     = (state == PHASE) || (state == WIDTH);

    always_ff @(posedge i_clk_10 or posedge i_rst) begin
      if (i_rst) begin
        state    <= IDLE;
        div_cnt  <= '0;
        us_cnt   <= '0;
        phase_sh <= '0;
        width_sh <= '0;
        pol_sh   <= 1'b0;
        per_sh   <= 1'b0;
        overrun  <= 1'b0;
      end else begin
        state    <= state_nx;
        div_cnt  <= div_cnt_nx;
        us_cnt   <= us_cnt_nx;
        phase_sh <= phase_sh_nx;
        width_sh <= width_sh_nx;
        pol_sh   <= pol_sh_nx;
        per_sh   <= per_sh_nx;
        overrun  <= overrun_nx;
      end
    end

    always_comb begin
      state_nx    = state;
      div_cnt_nx  = div_cnt;
      us_cnt_nx   = us_cnt;
      phase_sh_nx = phase_sh;
      width_sh_nx = width_sh;
      pol_sh_nx   = pol_sh;
      per_sh_nx   = per_sh;
      overrun_nx  = overrun;
      if (i_clr_overrun[k])
        overrun_nx = 1'b0;
      if (pps_edge && (state == ARMED || busy))
        div_cnt_nx = (div_cnt >= div_max) ? '0 : div_cnt + 1'b1;
      if (busy && us_tick)
        us_cnt_nx = us_cnt + 1'b1;
      // Stop (or loss of start) dominates every transition, including a fire
      if (!run) begin
        state_nx   = IDLE;
        div_cnt_nx = '0;
      end else begin
        case (state)
          IDLE: begin
            state_nx   = ARMED;
            div_cnt_nx = '0;
          end
          ARMED: begin
            if (fire) begin
              phase_sh_nx = phase_in;
              width_sh_nx = width_in;
              pol_sh_nx   = i_polarity[k];
              per_sh_nx   = i_periodic[k];
              us_cnt_nx   = '0;
              if (phase_in != '0)
                state_nx = PHASE;
              else if (width_in != '0)
                state_nx = WIDTH;
              else
                state_nx = i_periodic[k] ? ARMED : DONE;
            end
          end
          PHASE: begin
            if (fire)
              overrun_nx = 1'b1;
            if (us_tick && us_cnt == phase_sh - PHASE_WIDTH'(1)) begin
              us_cnt_nx = '0;
              if (width_sh != '0)
                state_nx = WIDTH;
              else
                state_nx = per_sh ? ARMED : DONE;
            end
          end
          WIDTH: begin
            if (fire)
              overrun_nx = 1'b1;
            if (us_tick && us_cnt == PHASE_WIDTH'(width_sh) - PHASE_WIDTH'(1))
              state_nx = per_sh ? ARMED : DONE;
          end
          DONE:    state_nx = DONE;
          default: state_nx = IDLE;
        endcase
      end
    end

    // Outside a pulse the live polarity drives the pin, so reset and IDLE show the inactive level
    assign o_pps_divided[k] = (state == WIDTH) ? ~pol_sh :
                              (state == PHASE) ?  pol_sh : i_polarity[k];
    assign o_active[k]      = (state == ARMED) || busy;
    assign o_overrun[k]     = overrun;
  end

endmodule

// File: tb/tb_pps_divider_multi.sv
// Directed bench for pps_divider_multi: four channels run concurrently against a 1000-cycle PPS,
// with hand-computed output vectors checked at key cycles.
`timescale 1ns/1ps
module tb_pps_divider_multi;

  logic        clk = 1'b0;
  logic        rst, pps_raw;
  logic [3:0]  start, stop, periodic, polarity, clr;
  logic [31:0] div_number, width_us;
  logic [95:0] phase_us;
  logic [3:0]  pps_divided, active, overrun;
  logic        pps_edge;

  int cyc;
  int vectors;
  int errors;

  pps_divider_multi #(.N_CH(4), .DATA_WIDTH(8), .PHASE_WIDTH(24), .CLKS_PER_US(10)) dut (
    .i_clk_10      (clk),
    .i_rst         (rst),
    .i_pps_raw     (pps_raw),
    .i_start       (start),
    .i_stop        (stop),
    .i_periodic    (periodic),
    .i_polarity    (polarity),
    .i_div_number  (div_number),
    .i_phase_us    (phase_us),
    .i_width_us    (width_us),
    .i_clr_overrun (clr),
    .o_pps_divided (pps_divided),
    .o_active      (active),
    .o_overrun     (overrun),
    .o_pps_edge    (pps_edge)
  );

  always #50 clk = ~clk;

  // Advance one clock; raw PPS is high for 100 cycles every 1000, first rising in cycle 10
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    pps_raw = (cyc >= 10) && (((cyc - 10) % 1000) < 100);
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask

  task automatic check_output(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s @cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  initial begin
    cyc        = 0;
    vectors    = 0;
    errors     = 0;
    rst        = 1'b1;
    pps_raw    = 1'b0;
    start      = 4'h0;
    stop       = 4'h0;
    clr        = 4'h0;
    polarity   = 4'b0100;
    periodic   = 4'b1011;
    div_number = {8'd1, 8'd1, 8'd3, 8'd1};
    phase_us   = {24'd0, 24'd0, 24'd100, 24'd0};
    width_us   = {8'd200, 8'd1, 8'd2, 8'd5};

    #5;
    check_output("reset_out", pps_divided, 4'b0100);
    check_output("reset_active", active, 4'b0000);
    check_output("reset_overrun", overrun, 4'b0000);
    check_output("reset_edge", {3'b000, pps_edge}, 4'b0000);

    goto(1);  rst = 1'b0;
    goto(2);  start = 4'hF;
    goto(5);  check_output("armed_active", active, 4'b1111);

    goto(12); check_output("edge_before", {3'b000, pps_edge}, 4'b0000);
    goto(13); check_output("edge_E", {3'b000, pps_edge}, 4'b0001);
              check_output("out_E", pps_divided, 4'b0100);
    goto(14); check_output("edge_after", {3'b000, pps_edge}, 4'b0000);
              check_output("out_E1", pps_divided, 4'b1001);
    goto(24); check_output("out_oneshot_end", pps_divided, 4'b1101);
              check_output("active_done", active, 4'b1011);
    goto(63); check_output("out_ch0_last", pps_divided, 4'b1101);
    goto(64); check_output("out_ch0_end", pps_divided, 4'b1100);

    goto(1013); check_output("overrun_pre", overrun, 4'b0000);
    goto(1014); check_output("overrun_set", overrun, 4'b1000);
                check_output("out_pps2", pps_divided, 4'b1111);
    goto(1034); check_output("out_ch1_end", pps_divided, 4'b1101);

    goto(1500); clr = 4'b1000; start = 4'b1011;
    goto(1501); clr = 4'b0000; start = 4'hF;
                check_output("overrun_clr", overrun, 4'b0000);
                check_output("active_rearm0", active, 4'b1011);
    goto(1503); check_output("active_rearm1", active, 4'b1111);

    goto(2014); check_output("out_pps3", pps_divided, 4'b0001);
    goto(2024); check_output("out_pps3_late", pps_divided, 4'b0101);
                check_output("active_done2", active, 4'b1011);
    goto(3014); check_output("out_pps4", pps_divided, 4'b1101);
    goto(4014); check_output("out_pps5", pps_divided, 4'b1111);

    goto(4030); check_output("out_prestop", pps_divided, 4'b1111);
                stop = 4'b0001;
    goto(4031); check_output("out_stop", pps_divided, 4'b1110);
                check_output("active_stop", active, 4'b1010);
    goto(4033); check_output("out_ch1_last", pps_divided, 4'b1110);
    goto(4034); check_output("out_ch1_end2", pps_divided, 4'b1100);
    goto(4040); stop = 4'b0000;
    goto(4042); check_output("active_restart", active, 4'b1011);

    goto(5014); check_output("out_pps6", pps_divided, 4'b0101);
    goto(7014); check_output("out_pps8", pps_divided, 4'b1111);
                check_output("overrun_late", overrun, 4'b1000);

    goto(7020); rst = 1'b1;
    #5;
    check_output("async_rst_out", pps_divided, 4'b0100);
    check_output("async_rst_active", active, 4'b0000);
    check_output("async_rst_overrun", overrun, 4'b0000);
    check_output("async_rst_edge", {3'b000, pps_edge}, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
